matdump_arb: RTL and testbench
==============================

# matdump_arb

Shares one element-serial matrix dump channel among NREQ debug requesters. Each requester offers a whole ROWS×COLS fixed-point matrix. The block grants one requester at a time in round-robin order and snapshots its matrix. It then streams the elements in row-major order over a valid/ready port tagged with source, row and column, so a single trace sink (printer, UART or log FIFO) can replace per-site display logic.

## Interface
Parameters:
- NREQ, 2: number of requesters (≥1)
- ROWS, 2: matrix rows (≥1), indexed ROWS:1
- COLS, 2: matrix columns (≥1), indexed COLS:1

Ports:
- g.clk  in  1  clock, via fixedp interface g; all logic on posedge
- g.reset  in  1  via fixedp interface g; one clock; reset is synchronous and active-high
- req_valid  in  NREQ  requester k offers a matrix
- req_ready  out  NREQ  one-hot; matrix k captured this cycle
- req_mat  in  [NREQ-1:0][ROWS:1][COLS:1][g.WIDTH-1:0]  offered matrices
- out_valid  out  1  element available
- out_ready  in  1  sink accepts element
- out_data  out  g.WIDTH  element value, fixed-point format of g
- out_src  out  max(1,$clog2(NREQ))  granted requester index
- out_row  out  $clog2(ROWS+1)  row index, 1..ROWS
- out_col  out  $clog2(COLS+1)  column index, 1..COLS
- out_first  out  1  element (1,1) of a matrix
- out_last  out  1  element (ROWS,COLS) of a matrix

## Operation
- States: IDLE, STREAM.
- IDLE:
  - Round-robin search starts at ptr and wraps modulo NREQ. The first k with req_valid[k] wins.
  - req_ready[k]=1 combinationally that cycle. req_mat[k] is copied into an internal buffer.
  - On the same clock: out_src←k, row←1, col←1, ptr←(k+1) mod NREQ, go to STREAM.
  - No req_valid asserted: stay in IDLE, all req_ready=0.
- STREAM:
  - out_valid=1; out_data=buffer[row][col].
  - out_first=(row==1 && col==1); out_last=(row==ROWS && col==COLS).
  - Handshake when out_valid && out_ready: if col<COLS then col+1, else col←1 and row+1.
  - Handshake on the out_last element: go to IDLE.
- req_ready is never asserted outside IDLE. Requesters hold req_valid and req_mat until they see req_ready.
- A requester that drops req_valid before grant is simply skipped; this is not an error.
- The buffer decouples the output from req_mat. Changes to req_mat after capture do not affect the stream.
- ROWS=COLS=1: the single element has out_first=out_last=1.
- NREQ=1: ptr stays 0; out_src is a 1-bit constant 0.

## Timing
- Reset values: out_valid=0, req_ready=0, out_first=0, out_last=0, out_data=0, out_src=0, out_row=1, out_col=1, ptr=0, state IDLE.
- Latency: capture in cycle N; first element out_valid in N+1.
- Minimum period per matrix is ROWS·COLS+1 cycles: one IDLE bubble between matrices, even with requests pending.
- While out_valid && !out_ready, out_data, out_src, out_row, out_col, out_first and out_last hold stable.
- out_valid does not depend combinationally on out_ready.
- Reset asserted mid-stream: on the next edge the remaining elements are discarded and all outputs take their reset values. The interrupted requester is not re-served unless it re-requests.
- Simultaneous requests: grant goes to the first asserted index at or after ptr. Others wait for a later IDLE cycle.
- A requester cannot be granted twice while another requester is continuously valid.

## Test plan
- Single matrix, NREQ=2, ROWS=COLS=2: requester 0 offers [[0.5,1.0],[-1.5,2.25]], out_ready=1.
  - req_ready[0] pulses one cycle.
  - Stream 0.5, 1.0, -1.5, 2.25 with (row,col) (1,1),(1,2),(2,1),(2,2).
  - out_first on element 1, out_last on element 4, out_src=0; out_valid drops after.
- Backpressure: same matrix, out_ready toggles 1,0,0,1,…
  - Each element is held stable through stall cycles.
  - The ordered sequence is unchanged.
  - Total cycles = 4 accepts + stalls + 1 capture.
- Contention: both requesters valid continuously from reset.
  - Grants alternate 0,1,0,1.
  - out_src matches each 4-element burst.
  - One idle cycle separates bursts.
- Reset mid-stream: assert g.reset after 2 of 4 elements accepted.
  - Next cycle out_valid=0 and out_row=out_col=1.
  - With no new request, no further elements appear.
- Capture isolation: change req_mat[0] to all zeros the cycle after req_ready[0].
  - The stream still shows the original values.
- Degenerate ROWS=COLS=1, NREQ=3, requesters 1 and 2 valid with ptr=0.
  - Requester 1 is granted first and emits one element with out_first=out_last=1.
  - Requester 2 is granted next.

Source files
------------

// File: rtl/matdump_arb.sv
// Round-robin arbiter that snapshots one requester's ROWS x COLS matrix and
// streams it row-major over a valid/ready port tagged with source, row and column.
module matdump_arb #(
    parameter int NREQ  = 2,
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int WIDTH = 16,
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int RW = $clog2(ROWS + 1),
    localparam int CW = $clog2(COLS + 1)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NREQ-1:0]                           req_valid,
    output logic [NREQ-1:0]                           req_ready,
    input  logic [NREQ-1:0][ROWS:1][COLS:1][WIDTH-1:0] req_mat,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [WIDTH-1:0]                          out_data,
    output logic [SW-1:0]                             out_src,
    output logic [RW-1:0]                             out_row,
    output logic [CW-1:0]                             out_col,
    output logic                                      out_first,
    output logic                                      out_last
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t                         state, nstate;
    logic [SW-1:0]                  ptr, gnt, nptr;
    logic                           found;
    logic                           row_end, col_end;
    logic [ROWS:1][COLS:1][WIDTH-1:0] mbuf;

    // Two passes give wrap-around priority: indices at/after ptr, then below it.
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        if (state == IDLE && !reset) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[k] && SW'(k) >= ptr) begin
                    found = 1'b1;
                    gnt   = SW'(k);
                end
            end
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[k]) begin
                    found = 1'b1;
                    gnt   = SW'(k);
                end
            end
        end
    end

    assign nptr = (gnt == SW'(NREQ - 1)) ? '0 : gnt + 1'b1;

    always_comb begin
        req_ready = '0;
        for (int k = 0; k < NREQ; k++)
            req_ready[k] = found && (gnt == SW'(k));
    end

    assign col_end   = (out_col == CW'(COLS));
    assign row_end   = (out_row == RW'(ROWS));
    assign out_valid = (state == STREAM);
    assign out_first = out_valid && (out_row == RW'(1)) && (out_col == CW'(1));
    assign out_last  = out_valid && row_end && col_end;

    always_comb begin
        out_data = '0;
        if (out_valid)
            for (int r = 1; r <= ROWS; r++)
                for (int c = 1; c <= COLS; c++)
                    if (out_row == RW'(r) && out_col == CW'(c))
                        out_data = mbuf[r][c];
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (found) nstate = STREAM;
            STREAM:  if (out_ready && out_last) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            out_src <= '0;
            out_row <= RW'(1);
            out_col <= CW'(1);
        end else begin
            state <= nstate;
            if (found) begin
                out_src <= gnt;
                out_row <= RW'(1);
                out_col <= CW'(1);
                ptr     <= nptr;
            end else if (out_valid && out_ready) begin
                if (col_end) begin
                    out_col <= CW'(1);
                    out_row <= row_end ? RW'(1) : out_row + 1'b1;
                end else begin
                    out_col <= out_col + 1'b1;
                end
            end
        end
    end

    // Snapshot needs no reset: it is only observed after a capture.
    always_ff @(posedge clk) begin
        if (found)
            for (int k = 0; k < NREQ; k++)
                if (gnt == SW'(k))
                    mbuf <= req_mat[k];
    end

endmodule

// File: tb/tb_matdump_arb.sv
// Scoreboard bench for matdump_arb: a 2x2/2-requester instance and a
// 1x1/3-requester instance share clock and reset.
module tb_matdump_arb;

    logic clk, rst;
    int   total = 0, bad = 0;

    logic [1:0]                  rv0, r0_ready;
    logic [1:0][2:1][2:1][15:0]  rm0;
    logic                        o0_valid, o0_ready, o0_first, o0_last;
    logic [15:0]                 o0_data;
    logic [0:0]                  o0_src;
    logic [1:0]                  o0_row, o0_col;

    logic [2:0]                  rv1, r1_ready;
    logic [2:0][1:1][1:1][15:0]  rm1;
    logic                        o1_valid, o1_ready, o1_first, o1_last;
    logic [15:0]                 o1_data;
    logic [1:0]                  o1_src;
    logic [0:0]                  o1_row, o1_col;

    logic [23:0] q0[$], q1[$];

    matdump_arb #(.NREQ(2), .ROWS(2), .COLS(2), .WIDTH(16)) u0 (
        .clk(clk), .reset(rst), .req_valid(rv0), .req_ready(r0_ready), .req_mat(rm0),
        .out_valid(o0_valid), .out_ready(o0_ready), .out_data(o0_data), .out_src(o0_src),
        .out_row(o0_row), .out_col(o0_col), .out_first(o0_first), .out_last(o0_last));

    matdump_arb #(.NREQ(3), .ROWS(1), .COLS(1), .WIDTH(16)) u1 (
        .clk(clk), .reset(rst), .req_valid(rv1), .req_ready(r1_ready), .req_mat(rm1),
        .out_valid(o1_valid), .out_ready(o1_ready), .out_data(o1_data), .out_src(o1_src),
        .out_row(o1_row), .out_col(o1_col), .out_first(o1_first), .out_last(o1_last));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Monitors: compare presented element against queue head; pop on handshake.
    always @(negedge clk) begin
        if (!rst && o0_valid) begin
            if (q0.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_elem0 got=%0h exp=none", o0_data);
            end else begin
                chk("elem0", {2'(o0_src), o0_row, o0_col, o0_data, o0_first, o0_last}, q0[0]);
                if (o0_ready) void'(q0.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && o1_valid) begin
            if (q1.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_elem1 got=%0h exp=none", o1_data);
            end else begin
                chk("elem1", {o1_src, 2'(o1_row), 2'(o1_col), o1_data, o1_first, o1_last}, q1[0]);
                if (o1_ready) void'(q1.pop_front());
            end
        end
    end

    task automatic push0(input logic [1:0] s, input logic [15:0] a, b, c, d);
        q0.push_back({s, 2'd1, 2'd1, a, 2'b10});
        q0.push_back({s, 2'd1, 2'd2, b, 2'b00});
        q0.push_back({s, 2'd2, 2'd1, c, 2'b00});
        q0.push_back({s, 2'd2, 2'd2, d, 2'b01});
    endtask

    task automatic load0(input logic k, input logic [15:0] a, b, c, d);
        rm0[k][1][1] = a; rm0[k][1][2] = b; rm0[k][2][1] = c; rm0[k][2][2] = d;
    endtask

    task automatic grant0();
        rv0 = 2'b01;
        @(negedge clk);
        chk("grant0", r0_ready, 2'b01);
        @(posedge clk); #1;
        rv0 = 2'b00;
    endtask

    // mode 0: sink always ready; mode 1: ready pattern 1,0,0,1,0,0,...
    task automatic run_stream(input int mode, output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            o0_ready = (mode == 0) || (i % 3 == 0);
            @(negedge clk);
            if (!o0_valid) break;
            chk("no_rdy_in_stream", r0_ready, 2'b00);
            cyc++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        o0_ready = 1'b1;
    endtask

    initial begin
        int cyc;
        int vcnt;
        rst = 1'b1; rv0 = '0; rv1 = '0; rm0 = '0; rm1 = '0;
        o0_ready = 1'b1; o1_ready = 1'b1;
        load0(1'b0, 16'h0080, 16'h0100, 16'hFE80, 16'h0240);  // 0.5 1.0 -1.5 2.25 (Q8.8)
        load0(1'b1, 16'h0011, 16'h0012, 16'h0021, 16'h0022);
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        @(negedge clk);
        chk("rst_valid",  o0_valid, 0);
        chk("rst_ready",  r0_ready, 0);
        chk("rst_first",  o0_first, 0);
        chk("rst_last",   o0_last, 0);
        chk("rst_data",   o0_data, 0);
        chk("rst_src",    o0_src, 0);
        chk("rst_row",    o0_row, 1);
        chk("rst_col",    o0_col, 1);
        chk("rst_valid1", o1_valid, 0);
        chk("rst_ready1", r1_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single matrix, sink always ready
        push0(2'd0, 16'h0080, 16'h0100, 16'hFE80, 16'h0240);
        grant0();
        run_stream(0, cyc);
        chk("single_cycles", cyc, 4);
        chk("single_drain", q0.size(), 0);

        // Backpressure: 4 accepts + 6 stalls
        push0(2'd0, 16'h0080, 16'h0100, 16'hFE80, 16'h0240);
        grant0();
        run_stream(1, cyc);
        chk("bp_cycles", cyc, 10);
        chk("bp_drain", q0.size(), 0);

        // Contention from reset: grants 0,1,0,1 with one idle bubble between bursts
        rst = 1'b1; rv0 = 2'b11;
        push0(2'd0, 16'h0080, 16'h0100, 16'hFE80, 16'h0240);
        push0(2'd1, 16'h0011, 16'h0012, 16'h0021, 16'h0022);
        push0(2'd0, 16'h0080, 16'h0100, 16'hFE80, 16'h0240);
        push0(2'd1, 16'h0011, 16'h0012, 16'h0021, 16'h0022);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("rr_grant", r0_ready, (c % 5 == 0) ? (((c / 5) % 2) ? 2'b10 : 2'b01) : 2'b00);
            @(posedge clk); #1;
            if (c == 19) rv0 = 2'b00;
        end
        @(negedge clk);
        chk("rr_drain", q0.size(), 0);
        chk("rr_idle", o0_valid, 0);
        @(posedge clk); #1;

        // Reset after two accepted elements
        push0(2'd0, 16'h0080, 16'h0100, 16'hFE80, 16'h0240);
        grant0();
        repeat (2) begin
            @(negedge clk);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_valid", o0_valid, 0);
        chk("mid_rst_row",   o0_row, 1);
        chk("mid_rst_col",   o0_col, 1);
        chk("mid_rst_left",  q0.size(), 2);
        q0.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        vcnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (o0_valid) vcnt++;
        end
        chk("mid_rst_silent", vcnt, 0);
        @(posedge clk); #1;

        // Capture isolation: zero the matrix right after the grant
        push0(2'd0, 16'h0080, 16'h0100, 16'hFE80, 16'h0240);
        grant0();
        load0(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
        run_stream(0, cyc);
        chk("iso_cycles", cyc, 4);
        chk("iso_drain", q0.size(), 0);

        // 1x1 matrices, three requesters, 1 and 2 valid with ptr=0
        rm1[0][1][1] = 16'h0999; rm1[1][1][1] = 16'h0111; rm1[2][1][1] = 16'h0222;
        q1.push_back({2'd1, 2'd1, 2'd1, 16'h0111, 2'b11});
        q1.push_back({2'd2, 2'd1, 2'd1, 16'h0222, 2'b11});
        rv1 = 3'b110;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("deg_grant", r1_ready, (c == 0) ? 3'b010 : (c == 2) ? 3'b100 : 3'b000);
            @(posedge clk); #1;
        end
        rv1 = 3'b000;
        @(negedge clk);
        chk("deg_drain", q1.size(), 0);
        chk("deg_idle", o1_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
